grid_scan_ctrl: RTL

Row-scan controller for the 8x8 LED grid driven through `tt_um_bluewatercrystal_sexy_grid`. It holds a double-buffered frame store, takes row writes from the host side, and sequences the grid one row at a time with a blanking slot between rows to prevent ghosting. New frames are committed atomically at a frame boundary, so the display never shows a torn frame.

---
 rtl/grid_scan_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/grid_scan_ctrl.sv
// Double-buffered 8x8 row-scan controller: one lit row at a time, a blank slot between rows.
// Latency: outputs are registered and follow the state entered at each edge; a commit swaps at the next frame boundary or in IDLE.
// Backpressure: wr_ready is low from an accepted commit until the swap, and writes/commits are dropped while it is low.
module grid_scan_ctrl #(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int DWELL = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    input  logic                    wr_en,
    input  logic [$clog2(ROWS)-1:0] wr_row,
    input  logic [COLS-1:0]         wr_data,
    input  logic                    commit,
    output logic                    wr_ready,
    output logic [ROWS-1:0]         row_sel,
    output logic [COLS-1:0]         col_data,
    output logic                    blank,
    output logic                    frame_start
);
    localparam int            RW       = $clog2(ROWS);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
    localparam logic [7:0]    LAST_CNT = 8'(DWELL - 1);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            swap_pending, do_swap;
    logic            row_ok, wr_acc, commit_acc;
    logic [COLS-1:0] disp   [ROWS];
    logic [COLS-1:0] shadow [ROWS];

    assign wr_ready   = ~swap_pending;
    assign row_ok     = 32'(wr_row) < ROWS;
    assign wr_acc     = wr_en & wr_ready & row_ok;
    assign commit_acc = commit & wr_ready;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        do_swap = 1'b0;
        case (state_q)
            IDLE: begin
                row_d   = '0;
                do_swap = swap_pending;
                if (ena) state_d = BLANK;
            end
            BLANK: begin
                state_d = SHOW;
                cnt_d   = '0;
            end
            SHOW: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = BLANK;
                    if (row_q == LAST_ROW) begin
                        row_d   = '0;
                        do_swap = swap_pending;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Dropping ena abandons the frame; a pending swap waits for IDLE rather than landing mid-abort.
        if (!ena) begin
            state_d = IDLE;
            row_d   = '0;
            if (state_q != IDLE) do_swap = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            row_q        <= '0;
            cnt_q        <= '0;
            swap_pending <= 1'b0;
            row_sel      <= '0;
            col_data     <= '0;
            blank        <= 1'b1;
            frame_start  <= 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                disp[r]   <= '0;
                shadow[r] <= '0;
            end
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            cnt_q       <= cnt_d;
            // SHOW is only entered from BLANK, where no swap happens, so disp is stable here.
            row_sel     <= (state_d == SHOW) ? (ROWS'(1) << row_d) : '0;
            col_data    <= (state_d == SHOW) ? disp[row_d] : '0;
            blank       <= (state_d != SHOW);
            frame_start <= (state_d == BLANK) && (row_d == '0);
            if (wr_acc) shadow[wr_row] <= wr_data;
            if (do_swap) begin
                for (int r = 0; r < ROWS; r++) disp[r] <= shadow[r];
                swap_pending <= 1'b0;
            end else if (commit_acc) begin
                swap_pending <= 1'b1;
            end
        end
    end
endmodule
